measure_scheduler: RTL and testbench

MEASURE_SCHEDULER -- requirements
Module: measure_scheduler

---
 rtl/meas_pkg.sv | 7 +
 rtl/seq_div.sv | 53 +++++
 rtl/measure_scheduler.sv | 167 ++++++++++++++++
 tb/tb_measure_scheduler.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/meas_pkg.sv
// Shared types and constants for the frequency/duty measurement scheduler.
package meas_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, DIV_FREQ, DIV_DUTY, PUBLISH} state_e;

    localparam int DUTY_SCALE = 100;
    localparam int DUTY_MAX   = 100;
endpackage

// File: rtl/seq_div.sv
// Restoring unsigned divider: one quotient bit per cycle, done pulses N cycles after start.
// A start with a zero divisor is ignored, so the divider never runs a divide-by-zero.
module seq_div #(
    parameter int N = 34
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [N-1:0] dividend_i,
    input  logic [N-1:0] divisor_i,
    output logic         done_o,
    output logic [N-1:0] quotient_o
);
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  rem_q, quo_q, dvs_q;
    logic [CW-1:0] cnt_q;
    logic          done_q;
    logic [N:0]    rem_sh;
    logic [N+1:0]  diff;
    logic          neg;

    // Remainder stays below the divisor, so the shifted trial fits in N+1 bits.
    assign rem_sh = {rem_q, quo_q[N-1]};
    assign diff   = {1'b0, rem_sh} - {2'b00, dvs_q};
    assign neg    = diff[N+1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i && divisor_i != '0) begin
                rem_q <= '0;
                quo_q <= dividend_i;
                dvs_q <= divisor_i;
                cnt_q <= CW'(N);
            end else if (cnt_q != '0) begin
                rem_q  <= neg ? rem_sh[N-1:0] : diff[N-1:0];
                quo_q  <= {quo_q[N-2:0], ~neg};
                cnt_q  <= cnt_q - 1'b1;
                done_q <= (cnt_q == CW'(1));
            end
        end
    end

    assign done_o     = done_q;
    assign quotient_o = quo_q;
endmodule

// File: rtl/measure_scheduler.sv
// Turns period/pulse edge counts into published frequency (Hz) and duty (%) via one shared divider.
// Define MEAS_SCHED_AVG_EN to average four accepted samples before each computation.
module measure_scheduler
    import meas_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int W           = 27,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic         MAX10_CLK1_50,
    input  logic         KEY0,
    input  logic         period_valid,
    input  logic [W-1:0] period_cnt,
    input  logic [W-1:0] pulse_cnt,
    output logic [W-1:0] freq_hz,
    output logic [6:0]   duty_pct,
    output logic         result_valid,
    output logic         no_signal,
    output logic         err_zero,
    output logic         busy
);
    localparam int N  = W + 7;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC);

    state_e        state_q, state_d;
    logic [W-1:0]  per_q, pls_q, pend_per_q, pend_pls_q, fq_q, freq_q;
    logic [6:0]    duty_q;
    logic          pend_q, rv_q, nosig_q, errz_q;
    logic [TW-1:0] to_cnt_q;

    logic          take, load_go, publish, timeout_evt;
    logic [W-1:0]  take_per, take_pls, ld_per, ld_pls;
    logic          div_start, div_done;
    logic [N-1:0]  div_dvd, div_quo;

    // Newest sample wins: a live period_valid beats a stale pending entry.
    assign take        = (state_q == IDLE) && (period_valid || pend_q);
    assign take_per    = period_valid ? period_cnt : pend_per_q;
    assign take_pls    = period_valid ? pulse_cnt  : pend_pls_q;
    assign timeout_evt = (state_q == IDLE) && (to_cnt_q == TO_MAX) && !nosig_q
                         && !period_valid && !pend_q;
    assign publish     = (state_q == DIV_DUTY && div_done) || (state_q == LOAD && per_q == '0);

`ifdef MEAS_SCHED_AVG_EN
    localparam int AW = W + 2;
    logic [AW-1:0] acc_per_q, acc_pls_q, sum_per, sum_pls;
    logic [1:0]    avg_cnt_q;

    assign sum_per = acc_per_q + AW'(take_per);
    assign sum_pls = acc_pls_q + AW'(take_pls);
    assign load_go = take && (avg_cnt_q == 2'd3);
    assign ld_per  = sum_per[AW-1:2];
    assign ld_pls  = sum_pls[AW-1:2];

    always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
        if (!KEY0) begin
            acc_per_q <= '0;
            acc_pls_q <= '0;
            avg_cnt_q <= '0;
        end else if (timeout_evt || load_go) begin
            acc_per_q <= '0;
            acc_pls_q <= '0;
            avg_cnt_q <= '0;
        end else if (take) begin
            acc_per_q <= sum_per;
            acc_pls_q <= sum_pls;
            avg_cnt_q <= avg_cnt_q + 2'd1;
        end
    end
`else
    assign load_go = take;
    assign ld_per  = take_per;
    assign ld_pls  = take_pls;
`endif

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        div_dvd   = N'(CLK_HZ);
        case (state_q)
            IDLE:     if (load_go) state_d = LOAD;
            LOAD: begin
                if (per_q == '0) begin
                    state_d = PUBLISH;
                end else begin
                    state_d   = DIV_FREQ;
                    div_start = 1'b1;
                end
            end
            DIV_FREQ: begin
                if (div_done) begin
                    state_d   = DIV_DUTY;
                    div_start = 1'b1;
                    div_dvd   = N'(pls_q) * N'(DUTY_SCALE);
                end
            end
            DIV_DUTY: if (div_done) state_d = PUBLISH;
            PUBLISH:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_q    <= IDLE;
            per_q      <= '0;
            pls_q      <= '0;
            pend_q     <= 1'b0;
            pend_per_q <= '0;
            pend_pls_q <= '0;
            to_cnt_q   <= '0;
            fq_q       <= '0;
            freq_q     <= '0;
            duty_q     <= '0;
            rv_q       <= 1'b0;
            nosig_q    <= 1'b0;
            errz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= period_valid ? '0 : (to_cnt_q == TO_MAX ? to_cnt_q : to_cnt_q + 1'b1);
            if (period_valid && state_q != IDLE) begin
                pend_q     <= 1'b1;
                pend_per_q <= period_cnt;
                pend_pls_q <= pulse_cnt;
            end else if (take) begin
                pend_q <= 1'b0;
            end
            if (load_go) begin
                per_q <= ld_per;
                pls_q <= ld_pls;
            end
            // A quotient wider than W bits cannot be represented; saturate instead of wrapping.
            if (state_q == DIV_FREQ && div_done)
                fq_q <= (|div_quo[N-1:W]) ? '1 : div_quo[W-1:0];
            rv_q <= publish || timeout_evt;
            if (publish) begin
                freq_q  <= (per_q == '0) ? '0 : fq_q;
                duty_q  <= (per_q == '0) ? '0 :
                           (pls_q > per_q) ? 7'(DUTY_MAX) : div_quo[6:0];
                errz_q  <= (per_q == '0);
                nosig_q <= 1'b0;
            end else if (timeout_evt) begin
                freq_q  <= '0;
                duty_q  <= '0;
                nosig_q <= 1'b1;
            end
        end
    end

    seq_div #(.N(N)) u_div (
        .clk_i      (MAX10_CLK1_50),
        .rst_ni     (KEY0),
        .start_i    (div_start),
        .dividend_i (div_dvd),
        .divisor_i  (N'(per_q)),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    assign freq_hz      = freq_q;
    assign duty_pct     = duty_q;
    assign result_valid = rv_q;
    assign no_signal    = nosig_q;
    assign err_zero     = errz_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_measure_scheduler.sv
// Directed bench for measure_scheduler with hand-computed expected results.
module tb_measure_scheduler;
    localparam int W  = 27;
    localparam int N  = W + 7;
    localparam int TO = 1000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pv = 1'b0;
    logic [W-1:0] pc = '0;
    logic [W-1:0] plc = '0;
    logic [W-1:0] freq;
    logic [6:0]   duty;
    logic         rv, nosig, errz, busy;

    int n_chk = 0;
    int n_fail = 0;
    int rv_cnt = 0;
    int base;

    always #10 clk = ~clk;

    measure_scheduler #(.CLK_HZ(50000000), .W(W), .TIMEOUT_CYC(TO)) dut (
        .MAX10_CLK1_50 (clk),
        .KEY0          (rst_n),
        .period_valid  (pv),
        .period_cnt    (pc),
        .pulse_cnt     (plc),
        .freq_hz       (freq),
        .duty_pct      (duty),
        .result_valid  (rv),
        .no_signal     (nosig),
        .err_zero      (errz),
        .busy          (busy)
    );

    always @(posedge clk) begin
        #1;
        if (rv) rv_cnt++;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int per, input int pls);
        @(negedge clk);
        pv = 1'b1;
        pc = W'(per);
        plc = W'(pls);
        @(negedge clk);
        pv = 1'b0;
    endtask

    task automatic wait_rv(input string tag, input int bound);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rv && k < bound);
        chk(tag, rv, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #5;
        chk("rst freq", freq, 0);
        chk("rst duty", duty, 0);
        chk("rst rv", rv, 0);
        chk("rst nosig", nosig, 0);
        chk("rst errz", errz, 0);
        chk("rst busy", busy, 0);
        wait_n(2);
        rst_n = 1'b1;
        wait_n(2);

        // 50 MHz / 50000 = 1000 Hz, 25000/50000 = 50 %, exact 2N+3 latency
        base = rv_cnt;
        send(50000, 25000);
        wait_n(5);
        chk("A busy", busy, 1);
        wait_n(2 * N + 2 - 5);
        chk("A rv early", rv, 0);
        wait_n(1);
        chk("A rv at 2N+3", rv, 1);
        chk("A freq", freq, 1000);
        chk("A duty", duty, 50);
        wait_n(5);
        chk("A rv count", rv_cnt - base, 1);
        chk("A idle", busy, 0);

        // zero period skips both divisions: publish one cycle after LOAD
        send(0, 5);
        wait_n(1);
        chk("Z rv", rv, 1);
        chk("Z freq", freq, 0);
        chk("Z duty", duty, 0);
        chk("Z errz", errz, 1);
        wait_n(3);

        // pulse longer than period clamps duty
        send(50, 60);
        wait_rv("C rv", 200);
        chk("C freq", freq, 1000000);
        chk("C duty", duty, 100);
        chk("C errz", errz, 0);
        wait_n(3);

        // two samples while busy: only the newest (400) is kept
        base = rv_cnt;
        send(100, 10);
        wait_n(5);
        send(200, 20);
        wait_n(3);
        send(400, 100);
        wait_rv("P rv1", 200);
        chk("P freq1", freq, 500000);
        chk("P duty1", duty, 10);
        wait_rv("P rv2", 200);
        chk("P freq2", freq, 125000);
        chk("P duty2", duty, 25);
        wait_n(100);
        chk("P rv count", rv_cnt - base, 2);

        // timeout: one result_valid, then next sample clears no_signal
        base = rv_cnt;
        wait_rv("T rv", 1500);
        chk("T nosig", nosig, 1);
        chk("T freq", freq, 0);
        chk("T duty", duty, 0);
        wait_n(50);
        chk("T rv count", rv_cnt - base, 1);
        send(50000, 25000);
        chk("T nosig held", nosig, 1);
        wait_rv("T2 rv", 200);
        chk("T2 nosig", nosig, 0);
        chk("T2 freq", freq, 1000);
        wait_n(3);

        // reset during the duty division aborts the sample
        send(1000, 250);
        wait_n(N + 10);
        chk("R busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("R freq", freq, 0);
        chk("R duty", duty, 0);
        chk("R busy0", busy, 0);
        chk("R rv", rv, 0);
        chk("R nosig", nosig, 0);
        wait_n(2);
        rst_n = 1'b1;
        base = rv_cnt;
        wait_n(150);
        chk("R no rv", rv_cnt - base, 0);
        send(100, 50);
        wait_rv("R2 rv", 200);
        chk("R2 freq", freq, 500000);
        chk("R2 duty", duty, 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
